if_id_tracker: RTL and testbench
================================

IF_ID_TRACKER -- requirements
Module: if_id_tracker

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, instruction address width.
REQ-002 Parameter DATA_WIDTH, default 32, instruction data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 counter  input  32 (signed integer)  monotonic cycle count from the enclosing trace unit.
REQ-006 if_busy  input  1  fetch stage busy; qualifies fetch capture.
REQ-007 if_ready  input  1  fetch stage may hand an instruction to decode.
REQ-008 instr_req  input  1  instruction memory request.
REQ-009 instr_addr  input  ADDR_WIDTH  instruction memory address.
REQ-010 instr_grant  input  1  instruction memory grant.
REQ-011 instr_rvalid  input  1  instruction read data valid.
REQ-012 instr_rdata  input  DATA_WIDTH  instruction read data.
REQ-013 is_decoding  input  1  decode stage currently decoding an instruction.
REQ-014 trace_data_ready  output  1  one-cycle pulse: trace_data_o holds a complete record.
REQ-015 trace_data_o  output  trace_output  completed record {addr, instr, if_start, if_end, id_start, id_end}; time fields 32-bit.

Function
REQ-016 The IF section SHALL implement states IF_IDLE, IF_WAIT_RVALID, IF_HOLD.
REQ-017 IF_IDLE: on instr_req & instr_grant & if_busy, capture instr_addr, if_start=counter, go IF_WAIT_RVALID; otherwise stay.
REQ-018 IF_WAIT_RVALID: on instr_rvalid, capture instr_rdata, if_end=counter; if if_ready, hand record to ID section this cycle, else go IF_HOLD.
REQ-019 Handoff in the same cycle as a new req&grant&if_busy SHALL start the new record (stay IF_WAIT_RVALID); else go IF_IDLE.
REQ-020 IF_HOLD: hand record over on first cycle with if_ready, then IF_IDLE; new grants ignored while in IF_HOLD.
REQ-021 Handoff SHALL be an internal one-cycle if_data_ready pulse with the IF record.
REQ-022 The ID section SHALL buffer handed-off records in a 2-entry FIFO; a handoff when full SHALL be dropped, contents unchanged.
REQ-023 ID states ID_IDLE, ID_DECODING: in ID_IDLE with FIFO non-empty and is_decoding high, id_start=counter, go ID_DECODING.
REQ-024 ID_DECODING: on first cycle is_decoding low, id_end=counter, pop FIFO head, register full record to trace_data_o, pulse trace_data_ready next cycle, go ID_IDLE.
REQ-025 A handoff into an empty FIFO SHALL be usable for ID start no earlier than the following cycle.
REQ-026 Simultaneous push and pop SHALL both succeed, including when full.
REQ-027 trace_data_o SHALL hold its last value between pulses; trace_data_ready high exactly one cycle per record.
REQ-028 Time fields SHALL copy counter verbatim; wrap-around passes through without correction.

Reset
REQ-029 rst high SHALL immediately force IF_IDLE, ID_IDLE, FIFO empty, trace_data_ready=0, trace_data_o all zeros, internal if_data_ready=0.
REQ-030 Reset mid-record SHALL discard all in-flight and buffered records; no partial record emitted after release.
REQ-031 First capture SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-032 trace_output typedef and IF/ID state enums SHALL live in shared package ryuki_datatypes.
REQ-033 The ID section SHALL be sub-module id_tracker (ports if_data_in, if_data_ready, is_decoding, counter, id_data_out, trace_data_ready); IF logic stays in the top module.

Verification
REQ-034 Grant at counter=5, rvalid at 7 with if_ready, decode 8..10 (low at 11) -> one pulse, record {addr, rdata, 5, 7, 8, 11}.
REQ-035 rvalid at 7 with if_ready low until 9 -> if_end=7, handoff at 9, no record lost.
REQ-036 Three handoffs while is_decoding stuck high -> third dropped; exactly two records emitted in order.
REQ-037 Back-to-back: rvalid and new req&grant same cycle -> two records, second if_start equals first if_end.
REQ-038 rst pulse during ID_DECODING -> outputs zero immediately, no trace_data_ready until a fresh fetch completes.
REQ-039 Grant with if_busy low -> ignored, no record produced.

Source files
------------

// File: rtl/if_id_tracker_pkg.sv
// Shared trace datatypes for the IF/ID tracker: record layouts, FSM state
// encodings and the record-merge helper used when an instruction retires
// from decode.
package ryuki_datatypes;

  localparam int unsigned TRACE_ADDR_W = 32;
  localparam int unsigned TRACE_DATA_W = 32;
  localparam int unsigned TRACE_TIME_W = 32;
  localparam int unsigned ID_FIFO_DEPTH = 2;

  typedef logic [TRACE_TIME_W-1:0] trace_time_t;

  // Record produced by the fetch section and handed to decode
  typedef struct packed {
    logic [TRACE_ADDR_W-1:0] addr;
    logic [TRACE_DATA_W-1:0] instr;
    trace_time_t             if_start;
    trace_time_t             if_end;
  } if_record_t;

  // Completed trace record presented to the enclosing trace unit
  typedef struct packed {
    logic [TRACE_ADDR_W-1:0] addr;
    logic [TRACE_DATA_W-1:0] instr;
    trace_time_t             if_start;
    trace_time_t             if_end;
    trace_time_t             id_start;
    trace_time_t             id_end;
  } trace_output;

  typedef enum logic [1:0] {
    IF_IDLE,
    IF_WAIT_RVALID,
    IF_HOLD
  } if_state_t;

  typedef enum logic {
    ID_IDLE,
    ID_DECODING
  } id_state_t;

  // Merge a fetch record with its decode window into a full trace record
  function automatic trace_output make_trace(input if_record_t  rec,
                                             input trace_time_t id_start,
                                             input trace_time_t id_end);
    trace_output t;
    t.addr     = rec.addr;
    t.instr    = rec.instr;
    t.if_start = rec.if_start;
    t.if_end   = rec.if_end;
    t.id_start = id_start;
    t.id_end   = id_end;
    return t;
  endfunction

endpackage

// File: rtl/if_id_tracker_id.sv
// Decode-side tracker: buffers fetch records in a 2-entry FIFO, times the
// decode window of the head record and emits the completed trace record
// with a one-cycle ready pulse.
module id_tracker
  import ryuki_datatypes::*;
(
  input  logic               clk,
  input  logic               rst,
  input  if_record_t         if_data_in,
  input  logic               if_data_ready,
  input  logic               is_decoding,
  input  logic signed [31:0] counter,
  output trace_output        id_data_out,
  output logic               trace_data_ready
);

  id_state_t   id_state;
  id_state_t   id_state_d;
  trace_time_t id_start_q;
  logic        start_cap;

  if_record_t  mem [ID_FIFO_DEPTH];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;

  assign fifo_full  = (count == 2'd2);
  assign fifo_empty = (count == 2'd0);

  // Retire the head record on the first non-decoding cycle of a window
  assign pop  = (id_state == ID_DECODING) && !is_decoding;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts
  assign push = if_data_ready && (!fifo_full || pop);

  // Decode FSM next-state: start a window only on a record already buffered
  always_comb begin
    id_state_d = id_state;
    start_cap  = 1'b0;
    case (id_state)
      ID_IDLE: begin
        if (!fifo_empty && is_decoding) begin
          start_cap  = 1'b1;
          id_state_d = ID_DECODING;
        end
      end
      ID_DECODING: begin
        if (!is_decoding) begin
          id_state_d = ID_IDLE;
        end
      end
      default: id_state_d = ID_IDLE;
    endcase
  end

  // Decode FSM state register and decode start timestamp
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_state   <= ID_IDLE;
      id_start_q <= '0;
    end else begin
      id_state <= id_state_d;
      if (start_cap) begin
        id_start_q <= trace_time_t'(counter);
      end
    end
  end

  // FIFO storage; contents are only meaningful under count, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= if_data_in;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Output record register, held between pulses, and the ready pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_data_out      <= '0;
      trace_data_ready <= 1'b0;
    end else begin
      trace_data_ready <= pop;
      if (pop) begin
        id_data_out <= make_trace(mem[rd_ptr], id_start_q, trace_time_t'(counter));
      end
    end
  end

endmodule

// File: rtl/if_id_tracker.sv
// IF/ID pipeline tracker: times each instruction fetch (grant to rvalid)
// and hands the fetch record to the decode tracker, which completes it
// with the decode window and presents it as a trace record.
module if_id_tracker
  import ryuki_datatypes::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic signed [31:0]    counter,
  input  logic                  if_busy,
  input  logic                  if_ready,
  input  logic                  instr_req,
  input  logic [ADDR_WIDTH-1:0] instr_addr,
  input  logic                  instr_grant,
  input  logic                  instr_rvalid,
  input  logic [DATA_WIDTH-1:0] instr_rdata,
  input  logic                  is_decoding,
  output logic                  trace_data_ready,
  output trace_output           trace_data_o
);

  if_state_t   if_state;
  if_state_t   if_state_d;

  logic [TRACE_ADDR_W-1:0] addr_q;
  logic [TRACE_DATA_W-1:0] instr_q;
  trace_time_t             if_start_q;
  trace_time_t             if_end_q;

  logic        fetch_start;
  logic        new_fetch;
  logic        cap_rdata;
  logic        if_data_ready;
  if_record_t  if_data_in;

  assign fetch_start = instr_req && instr_grant && if_busy;

  // Fetch FSM next-state and handoff. The handoff on rvalid is built from
  // the live rdata/counter so decode sees the record at the end of the
  // rvalid cycle; the captured copy is only needed when decode is not ready.
  always_comb begin
    if_state_d          = if_state;
    new_fetch           = 1'b0;
    cap_rdata           = 1'b0;
    if_data_ready       = 1'b0;
    if_data_in.addr     = addr_q;
    if_data_in.instr    = instr_q;
    if_data_in.if_start = if_start_q;
    if_data_in.if_end   = if_end_q;
    case (if_state)
      IF_IDLE: begin
        if (fetch_start) begin
          new_fetch  = 1'b1;
          if_state_d = IF_WAIT_RVALID;
        end
      end
      IF_WAIT_RVALID: begin
        if (instr_rvalid) begin
          cap_rdata = 1'b1;
          if (if_ready) begin
            if_data_ready     = 1'b1;
            if_data_in.instr  = TRACE_DATA_W'(instr_rdata);
            if_data_in.if_end = trace_time_t'(counter);
            if (fetch_start) begin
              new_fetch  = 1'b1;
              if_state_d = IF_WAIT_RVALID;
            end else begin
              if_state_d = IF_IDLE;
            end
          end else begin
            if_state_d = IF_HOLD;
          end
        end
      end
      IF_HOLD: begin
        if (if_ready) begin
          if_data_ready = 1'b1;
          if_state_d    = IF_IDLE;
        end
      end
      default: if_state_d = IF_IDLE;
    endcase
  end

  // Fetch FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_state <= IF_IDLE;
    end else begin
      if_state <= if_state_d;
    end
  end

  // Fetch record capture: address/start on grant, data/end on rvalid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      instr_q    <= '0;
      if_start_q <= '0;
      if_end_q   <= '0;
    end else begin
      if (new_fetch) begin
        addr_q     <= TRACE_ADDR_W'(instr_addr);
        if_start_q <= trace_time_t'(counter);
      end
      if (cap_rdata) begin
        instr_q  <= TRACE_DATA_W'(instr_rdata);
        if_end_q <= trace_time_t'(counter);
      end
    end
  end

  id_tracker u_id_tracker (
    .clk              (clk),
    .rst              (rst),
    .if_data_in       (if_data_in),
    .if_data_ready    (if_data_ready),
    .is_decoding      (is_decoding),
    .counter          (counter),
    .id_data_out      (trace_data_o),
    .trace_data_ready (trace_data_ready)
  );

endmodule

// File: tb/tb_if_id_tracker.sv
// Directed bench for if_id_tracker: each task drives one scenario with
// explicit counter values and checks the emitted trace records.
module tb_if_id_tracker;
  import ryuki_datatypes::*;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [31:0] counter;
  logic               if_busy;
  logic               if_ready;
  logic               instr_req;
  logic [31:0]        instr_addr;
  logic               instr_grant;
  logic               instr_rvalid;
  logic [31:0]        instr_rdata;
  logic               is_decoding;
  logic               trace_data_ready;
  trace_output        trace_data_o;

  int total = 0;
  int bad   = 0;

  trace_output recq[$];

  if_id_tracker #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .counter          (counter),
    .if_busy          (if_busy),
    .if_ready         (if_ready),
    .instr_req        (instr_req),
    .instr_addr       (instr_addr),
    .instr_grant      (instr_grant),
    .instr_rvalid     (instr_rvalid),
    .instr_rdata      (instr_rdata),
    .is_decoding      (is_decoding),
    .trace_data_ready (trace_data_ready),
    .trace_data_o     (trace_data_o)
  );

  always #5 clk = ~clk;

  // Record every ready pulse, sampled mid-cycle
  always @(negedge clk) begin
    if (trace_data_ready === 1'b1) recq.push_back(trace_data_o);
  end

  function automatic trace_output mk(input logic [31:0] a, input logic [31:0] d,
                                     input int s1, input int e1, input int s2, input int e2);
    trace_output t;
    t.addr = a; t.instr = d;
    t.if_start = s1; t.if_end = e1; t.id_start = s2; t.id_end = e2;
    return t;
  endfunction

  // One clock cycle: g = req&grant, b = if_busy, v = rvalid, r = if_ready, d = is_decoding
  task automatic cyc(input int c, input bit g, input bit b, input bit v, input bit r,
                     input bit d, input logic [31:0] a, input logic [31:0] dat);
    counter = c; instr_req = g; instr_grant = g; if_busy = b; instr_rvalid = v;
    if_ready = r; is_decoding = d; instr_addr = a; instr_rdata = dat;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int c, input int n);
    for (int i = 0; i < n; i++) cyc(c + i, 0, 0, 0, 0, 0, 32'h0BAD_0BAD, 32'h0BAD_0BAD);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, '0, '0);
    cyc(1, 0, 0, 0, 0, 0, '0, '0);
    total++;
    if (trace_data_ready !== 1'b0) begin
      bad++; $display("FAIL reset_ready: got %b want 0", trace_data_ready);
    end
    total++;
    if (trace_data_o !== '0) begin
      bad++; $display("FAIL reset_data: got %h want 0", trace_data_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    trace_output e;
    recq.delete();
    e = mk(32'h0000_1000, 32'hCAFE_0001, 5, 7, 8, 11);
    cyc(5, 1, 1, 0, 0, 0, 32'h0000_1000, 32'h1111_1111);
    cyc(6, 0, 1, 0, 0, 0, 32'h2222_2222, 32'h2222_2222);
    cyc(7, 0, 1, 1, 1, 0, 32'h3333_3333, 32'hCAFE_0001);
    cyc(8, 0, 0, 0, 0, 1, 32'h4444_4444, 32'h4444_4444);
    cyc(9, 0, 0, 0, 0, 1, 32'h4444_4444, 32'h4444_4444);
    cyc(10, 0, 0, 0, 0, 1, 32'h4444_4444, 32'h4444_4444);
    cyc(11, 0, 0, 0, 0, 0, 32'h4444_4444, 32'h4444_4444);
    total++;
    if (trace_data_ready !== 1'b1) begin
      bad++; $display("FAIL basic_pulse: got %b want 1", trace_data_ready);
    end
    total++;
    if (trace_data_o !== e) begin
      bad++; $display("FAIL basic_record: got %h want %h", trace_data_o, e);
    end
    cyc(12, 0, 0, 0, 0, 0, '0, '0);
    total++;
    if (trace_data_ready !== 1'b0) begin
      bad++; $display("FAIL basic_pulse_width: got %b want 0", trace_data_ready);
    end
    total++;
    if (trace_data_o !== e) begin
      bad++; $display("FAIL basic_hold: got %h want %h", trace_data_o, e);
    end
    idle(13, 3);
    total++;
    if (recq.size() != 1) begin
      bad++; $display("FAIL basic_count: got %0d want 1", recq.size());
    end
  endtask

  task automatic test_hold();
    trace_output e;
    recq.delete();
    e = mk(32'h0000_2000, 32'hBEEF_0002, 60, 62, 65, 67);
    cyc(60, 1, 1, 0, 0, 0, 32'h0000_2000, 32'h0);
    cyc(61, 0, 1, 0, 0, 0, 32'h0, 32'h0);
    cyc(62, 0, 1, 1, 0, 0, 32'h0, 32'hBEEF_0002);
    cyc(63, 1, 1, 0, 0, 0, 32'h0000_9999, 32'h5555_5555);
    cyc(64, 0, 1, 0, 1, 0, 32'h0, 32'h6666_6666);
    cyc(65, 0, 1, 1, 1, 1, 32'h0, 32'h7777_7777);
    cyc(66, 0, 0, 0, 0, 1, 32'h0, 32'h0);
    cyc(67, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    idle(68, 4);
    total++;
    if (recq.size() != 1) begin
      bad++; $display("FAIL hold_count: got %0d want 1", recq.size());
    end
    if (recq.size() > 0) begin
      total++;
      if (recq[0] !== e) begin
        bad++; $display("FAIL hold_record: got %h want %h", recq[0], e);
      end
    end
  endtask

  task automatic test_drop_when_full();
    trace_output e[2];
    recq.delete();
    e[0] = mk(32'h0000_3001, 32'hD000_0001, 20, 21, 22, 26);
    e[1] = mk(32'h0000_3002, 32'hD000_0002, 21, 22, 27, 28);
    cyc(20, 1, 1, 0, 0, 0, 32'h0000_3001, 32'h0);
    cyc(21, 1, 1, 1, 1, 0, 32'h0000_3002, 32'hD000_0001);
    cyc(22, 1, 1, 1, 1, 1, 32'h0000_3003, 32'hD000_0002);
    cyc(23, 0, 1, 1, 1, 1, 32'h0, 32'hD000_0003);
    cyc(24, 0, 0, 0, 0, 1, 32'h0, 32'h0);
    cyc(25, 0, 0, 0, 0, 1, 32'h0, 32'h0);
    cyc(26, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    cyc(27, 0, 0, 0, 0, 1, 32'h0, 32'h0);
    cyc(28, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    cyc(29, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    cyc(30, 0, 0, 0, 0, 1, 32'h0, 32'h0);
    cyc(31, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    idle(32, 3);
    total++;
    if (recq.size() != 2) begin
      bad++; $display("FAIL drop_count: got %0d want 2", recq.size());
    end
    for (int i = 0; i < 2; i++) begin
      if (recq.size() > i) begin
        total++;
        if (recq[i] !== e[i]) begin
          bad++; $display("FAIL drop_record%0d: got %h want %h", i, recq[i], e[i]);
        end
      end
    end
  endtask

  task automatic test_full_push_pop();
    trace_output e[3];
    recq.delete();
    e[0] = mk(32'h0000_4001, 32'hE000_0001, 40, 41, 42, 44);
    e[1] = mk(32'h0000_4002, 32'hE000_0002, 41, 42, 45, 46);
    e[2] = mk(32'h0000_4003, 32'hE000_0003, 42, 44, 47, 48);
    cyc(40, 1, 1, 0, 0, 0, 32'h0000_4001, 32'h0);
    cyc(41, 1, 1, 1, 1, 0, 32'h0000_4002, 32'hE000_0001);
    cyc(42, 1, 1, 1, 1, 1, 32'h0000_4003, 32'hE000_0002);
    cyc(43, 0, 1, 0, 0, 1, 32'h0, 32'h0);
    cyc(44, 0, 1, 1, 1, 0, 32'h0, 32'hE000_0003);
    cyc(45, 0, 0, 0, 0, 1, 32'h0, 32'h0);
    cyc(46, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    cyc(47, 0, 0, 0, 0, 1, 32'h0, 32'h0);
    cyc(48, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    idle(49, 3);
    total++;
    if (recq.size() != 3) begin
      bad++; $display("FAIL pushpop_count: got %0d want 3", recq.size());
    end
    for (int i = 0; i < 3; i++) begin
      if (recq.size() > i) begin
        total++;
        if (recq[i] !== e[i]) begin
          bad++; $display("FAIL pushpop_record%0d: got %h want %h", i, recq[i], e[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    trace_output e[2];
    recq.delete();
    e[0] = mk(32'h0000_5001, 32'hF000_0001, 100, 101, 102, 103);
    e[1] = mk(32'h0000_5002, 32'hF000_0002, 101, 102, 104, 105);
    cyc(100, 1, 1, 0, 0, 0, 32'h0000_5001, 32'h0);
    cyc(101, 1, 1, 1, 1, 0, 32'h0000_5002, 32'hF000_0001);
    cyc(102, 0, 1, 1, 1, 1, 32'h0, 32'hF000_0002);
    cyc(103, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    cyc(104, 0, 0, 0, 0, 1, 32'h0, 32'h0);
    cyc(105, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    idle(106, 3);
    total++;
    if (recq.size() != 2) begin
      bad++; $display("FAIL b2b_count: got %0d want 2", recq.size());
    end
    if (recq.size() == 2) begin
      total++;
      if (recq[1].if_start !== recq[0].if_end) begin
        bad++; $display("FAIL b2b_chain: got if_start=%0d want %0d", recq[1].if_start, recq[0].if_end);
      end
      for (int i = 0; i < 2; i++) begin
        total++;
        if (recq[i] !== e[i]) begin
          bad++; $display("FAIL b2b_record%0d: got %h want %h", i, recq[i], e[i]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    trace_output e;
    recq.delete();
    e = mk(32'h0000_6000, 32'hA5A5_A5A5, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, 1);
    cyc(-2, 1, 1, 0, 0, 0, 32'h0000_6000, 32'h0);
    cyc(-1, 0, 1, 1, 1, 0, 32'h0, 32'hA5A5_A5A5);
    cyc(0, 0, 0, 0, 0, 1, 32'h0, 32'h0);
    cyc(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    idle(2, 3);
    total++;
    if (recq.size() != 1) begin
      bad++; $display("FAIL wrap_count: got %0d want 1", recq.size());
    end
    if (recq.size() > 0) begin
      total++;
      if (recq[0] !== e) begin
        bad++; $display("FAIL wrap_record: got %h want %h", recq[0], e);
      end
    end
  endtask

  task automatic test_busy_low();
    recq.delete();
    cyc(200, 1, 0, 0, 0, 0, 32'h0000_7000, 32'h0);
    cyc(201, 0, 0, 1, 1, 0, 32'h0, 32'h1234_5678);
    cyc(202, 0, 0, 0, 0, 1, 32'h0, 32'h0);
    cyc(203, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    idle(204, 3);
    total++;
    if (recq.size() != 0) begin
      bad++; $display("FAIL busy_low_count: got %0d want 0", recq.size());
    end
  endtask

  task automatic test_reset_mid_decode();
    trace_output e;
    e = mk(32'h0000_8002, 32'h8888_0002, 320, 321, 322, 323);
    cyc(300, 1, 1, 0, 0, 0, 32'h0000_8001, 32'h0);
    cyc(301, 0, 1, 1, 1, 0, 32'h0, 32'h8888_0001);
    cyc(302, 0, 0, 0, 0, 1, 32'h0, 32'h0);
    cyc(303, 0, 0, 0, 0, 1, 32'h0, 32'h0);
    // trace_data_o still holds the earlier record here; reset must clear it without a clock
    #2 rst = 1'b1;
    #1;
    total++;
    if (trace_data_o !== '0) begin
      bad++; $display("FAIL rst_async_data: got %h want 0", trace_data_o);
    end
    total++;
    if (trace_data_ready !== 1'b0) begin
      bad++; $display("FAIL rst_async_ready: got %b want 0", trace_data_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    recq.delete();
    cyc(320, 1, 1, 0, 0, 1, 32'h0000_8002, 32'h0);
    cyc(321, 0, 1, 1, 1, 0, 32'h0, 32'h8888_0002);
    cyc(322, 0, 0, 0, 0, 1, 32'h0, 32'h0);
    cyc(323, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    idle(324, 3);
    total++;
    if (recq.size() != 1) begin
      bad++; $display("FAIL rst_after_count: got %0d want 1", recq.size());
    end
    if (recq.size() > 0) begin
      total++;
      if (recq[0] !== e) begin
        bad++; $display("FAIL rst_after_record: got %h want %h", recq[0], e);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    counter = 0; instr_req = 0; instr_grant = 0; if_busy = 0; if_ready = 0;
    instr_rvalid = 0; is_decoding = 0; instr_addr = '0; instr_rdata = '0;
    #1;
    test_reset();
    test_basic();
    test_hold();
    test_drop_when_full();
    test_full_push_pop();
    test_back_to_back();
    test_wrap();
    test_busy_low();
    test_reset_mid_decode();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
